// File: rtl/vlane_pkg.sv
// Shared types for the vector lane.
// Contents: opcode, operand-mode and control-FSM enums, plus a clog2 helper
// that never returns 0. A zero-width field cannot be declared, so the helper
// always gives at least 1 bit.
package vlane_pkg;

    localparam int unsigned op_w = 3;

    typedef enum logic [op_w-1:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpMov
    } op_e;

    typedef enum logic {
        ModeVv,
        ModeVs
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    function automatic int unsigned safe_clog2(input int unsigned x);
        return (x < 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_counter_set_en.sv
// Up-counter with synchronous load and count enable.
// Ports: clk_i, reset_i  clock, synchronous active-high reset (to reset_val_p)
//        set_i, val_i    load val_i; takes priority over en_i
//        en_i            increment by one
//        count_o         current count
module bsg_counter_set_en
    import vlane_pkg::*;
#(
    parameter int unsigned max_val_p   = 1,
    parameter int unsigned width_p     = safe_clog2(max_val_p + 1),
    parameter int unsigned reset_val_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               set_i,
    input  logic               en_i,
    input  logic [width_p-1:0] val_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (set_i) begin
            count_d = val_i;
        end else if (en_i) begin
            count_d = count_q + width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= width_p'(reset_val_p);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vlane_alu.sv
// Combinational element ALU for the vector lane's execute stage.
// Ports: a_i, b_i  operands (vdw_p bits)
//        op_i      operation select (op_e)
//        result_o  result; ADD/SUB wrap, shifts use the low clog2(vdw_p) bits of b_i
module vlane_alu
    import vlane_pkg::*;
#(
    parameter int unsigned vdw_p = 32
) (
    input  logic [vdw_p-1:0] a_i,
    input  logic [vdw_p-1:0] b_i,
    input  op_e              op_i,
    output logic [vdw_p-1:0] result_o
);

    localparam int unsigned sh_w = safe_clog2(vdw_p);

    logic [sh_w-1:0] shamt;
    assign shamt = b_i[sh_w-1:0];

    always_comb begin
        result_o = b_i;
        unique case (op_i)
            OpAdd:   result_o = a_i + b_i;
            OpSub:   result_o = a_i - b_i;
            OpAnd:   result_o = a_i & b_i;
            OpOr:    result_o = a_i | b_i;
            OpXor:   result_o = a_i ^ b_i;
            OpSll:   result_o = a_i << shamt;
            OpSrl:   result_o = a_i >> shamt;
            OpMov:   result_o = b_i;
            default: result_o = b_i;
        endcase
    end

endmodule

// File: rtl/vlane_pipelined.sv
// One lane of a strided vector unit. Elements my_id_i, my_id_i+lanes_p, ... are
// read from the regfile, pass through an EX stage (ALU) and a WB stage, and are
// written back two cycles after their read.
// Ports: clk_i, reset_i        clock, synchronous active-high reset
//        my_id_i               static lane index
//        start_i / ready_o     request / idle handshake
//        op_i, mode_i, scalar_i operation, VV/VS select, scalar operand
//        r_addr_o, r0/r1_data_i regfile read port (combinational data)
//        w_addr_o, w_data_o, w_en_o regfile write port
//        done_o                one-cycle completion pulse
module vlane_pipelined
    import vlane_pkg::*;
#(
    parameter int unsigned vlen_p     = 8,
    parameter int unsigned vdw_p      = 32,
    parameter int unsigned lanes_p    = 4,
    parameter int unsigned op_width_p = 3,
    localparam int unsigned aw        = safe_clog2(vlen_p),
    localparam int unsigned idw       = safe_clog2(lanes_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [idw-1:0]        my_id_i,
    input  logic                  start_i,
    output logic                  ready_o,
    input  logic [op_width_p-1:0] op_i,
    input  logic                  mode_i,
    input  logic [vdw_p-1:0]      scalar_i,
    output logic [aw-1:0]         r_addr_o,
    input  logic [vdw_p-1:0]      r0_data_i,
    input  logic [vdw_p-1:0]      r1_data_i,
    output logic [aw-1:0]         w_addr_o,
    output logic [vdw_p-1:0]      w_data_o,
    output logic                  w_en_o,
    output logic                  done_o
);

    localparam int unsigned epl = vlen_p / lanes_p;
    localparam int unsigned cw  = safe_clog2(epl);

    state_e                  state_q, state_d;
    logic                    drain_q, drain_d;
    logic [op_width_p-1:0]   op_q, op_d;
    mode_e                   mode_q, mode_d;
    logic [vdw_p-1:0]        scalar_q, scalar_d;

    logic                    ex_valid_q, ex_valid_d;
    logic [vdw_p-1:0]        ex_a_q, ex_a_d;
    logic [vdw_p-1:0]        ex_b_q, ex_b_d;
    logic [aw-1:0]           ex_addr_q, ex_addr_d;

    logic                    wb_valid_q, wb_valid_d;
    logic [vdw_p-1:0]        wb_data_q, wb_data_d;
    logic [aw-1:0]           wb_addr_q, wb_addr_d;

    logic [cw-1:0]           k;
    logic                    accept, issue, last;
    logic [aw-1:0]           r_addr_issue;
    logic [vdw_p-1:0]        alu_result;

    assign accept = (state_q == StIdle) && start_i;
    assign issue  = (state_q == StIssue);
    assign last   = (k == cw'(epl - 1));

    // Element index; cleared on accept, held at epl-1 on the final ISSUE cycle.
    bsg_counter_set_en #(
        .max_val_p  (epl - 1),
        .width_p    (cw),
        .reset_val_p(0)
    ) u_elem_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .set_i  (accept),
        .en_i   (issue && !last),
        .val_i  ('0),
        .count_o(k)
    );

    // Strided element address, truncated to the regfile address width.
    assign r_addr_issue = aw'(32'(k) * lanes_p + 32'(my_id_i));
    assign r_addr_o     = issue ? r_addr_issue : '0;

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        op_d     = op_q;
        mode_d   = mode_q;
        scalar_d = scalar_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StIssue;
                    op_d     = op_i;
                    mode_d   = mode_e'(mode_i);
                    scalar_d = scalar_i;
                end
            end
            StIssue: begin
                if (last) begin
                    state_d = StDrain;
                    drain_d = 1'b0;
                end
            end
            // Two cycles: lets the last element pass EX and WB.
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ex_valid_d = issue;
        ex_a_d     = r0_data_i;
        ex_b_d     = (mode_q == ModeVs) ? scalar_q : r1_data_i;
        ex_addr_d  = r_addr_issue;
        wb_valid_d = ex_valid_q;
        wb_data_d  = alu_result;
        wb_addr_d  = ex_addr_q;
    end

    vlane_alu #(
        .vdw_p(vdw_p)
    ) u_alu (
        .a_i     (ex_a_q),
        .b_i     (ex_b_q),
        .op_i    (op_e'(op_q[op_w-1:0])),
        .result_o(alu_result)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            drain_q    <= 1'b0;
            op_q       <= '0;
            mode_q     <= ModeVv;
            scalar_q   <= '0;
            ex_valid_q <= 1'b0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_addr_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            op_q       <= op_d;
            mode_q     <= mode_d;
            scalar_q   <= scalar_d;
            ex_valid_q <= ex_valid_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_addr_q  <= ex_addr_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_addr_q  <= wb_addr_d;
        end
    end

    assign ready_o  = (state_q == StIdle);
    assign done_o   = (state_q == StDone);
    assign w_en_o   = wb_valid_q;
    assign w_addr_o = wb_addr_q;
    assign w_data_o = wb_data_q;

endmodule

// File: tb/tb_vlane_pipelined.sv
// Bench for vlane_pipelined: an 8-element/4-lane instance (lane 1) and a
// 4-element/4-lane instance (lane 3), each reading from a bench-side regfile.
module tb_vlane_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start8, start4, mode;
    logic [2:0]  op;
    logic [31:0] scalar;

    logic [2:0]  r_addr8, w_addr8;
    logic [31:0] r0_8, r1_8, w_data8;
    logic        ready8, w_en8, done8;

    logic [1:0]  r_addr4, w_addr4;
    logic [31:0] r0_4, r1_4, w_data4;
    logic        ready4, w_en4, done4;

    logic [31:0] rf0 [8];
    logic [31:0] rf1 [8];
    logic [31:0] rf4a [4];
    logic [31:0] rf4b [4];

    assign r0_8 = rf0[r_addr8];
    assign r1_8 = rf1[r_addr8];
    assign r0_4 = rf4a[r_addr4];
    assign r1_4 = rf4b[r_addr4];

    vlane_pipelined #(
        .vlen_p(8), .vdw_p(32), .lanes_p(4), .op_width_p(3)
    ) dut8 (
        .clk_i(clk), .reset_i(reset), .my_id_i(2'd1), .start_i(start8), .ready_o(ready8),
        .op_i(op), .mode_i(mode), .scalar_i(scalar), .r_addr_o(r_addr8),
        .r0_data_i(r0_8), .r1_data_i(r1_8), .w_addr_o(w_addr8), .w_data_o(w_data8),
        .w_en_o(w_en8), .done_o(done8)
    );

    vlane_pipelined #(
        .vlen_p(4), .vdw_p(32), .lanes_p(4), .op_width_p(3)
    ) dut4 (
        .clk_i(clk), .reset_i(reset), .my_id_i(2'd3), .start_i(start4), .ready_o(ready4),
        .op_i(op), .mode_i(mode), .scalar_i(scalar), .r_addr_o(r_addr4),
        .r0_data_i(r0_4), .r1_data_i(r1_4), .w_addr_o(w_addr4), .w_data_o(w_data4),
        .w_en_o(w_en4), .done_o(done4)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_wd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference element operation straight from the opcode table.
    function automatic logic [31:0] ref_alu(input int o, input logic [31:0] a,
                                            input logic [31:0] b);
        case (o)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << (b % 32);
            6: return a >> (b % 32);
            default: return b;
        endcase
    endfunction

    // One operation on dut8 started at edge 0; reads expected in cycles 1-2,
    // writes in cycles 3-4, done in cycle 5, idle again in cycle 6.
    task automatic run8(input logic [2:0] o, input logic m, input logic [31:0] s,
                        input bit use_fixed, input logic [31:0] fixed, input string tag);
        logic [31:0] ea [2];
        logic [31:0] ed [2];
        for (int k = 0; k < 2; k++) begin
            ea[k] = (k * 4 + 1) % 8;
            ed[k] = use_fixed ? fixed : ref_alu(int'(o), rf0[ea[k]], m ? s : rf1[ea[k]]);
        end
        @(negedge clk);
        op = o; mode = m; scalar = s; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        op = 3'($urandom); mode = 1'($urandom); scalar = $urandom;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d ready", tag, c), 32'(ready8), 32'(c == 6));
            chk($sformatf("%s c%0d done", tag, c), 32'(done8), 32'(c == 5));
            chk($sformatf("%s c%0d w_en", tag, c), 32'(w_en8), 32'(c == 3 || c == 4));
            if (c <= 2) chk($sformatf("%s c%0d r_addr", tag, c), 32'(r_addr8), ea[c-1]);
            else        chk($sformatf("%s c%0d r_addr", tag, c), 32'(r_addr8), 32'd0);
            if (w_en8 && (c == 3 || c == 4)) begin
                chk($sformatf("%s c%0d w_addr", tag, c), 32'(w_addr8), ea[c-3]);
                chk($sformatf("%s c%0d w_data", tag, c), w_data8, ed[c-3]);
                last_wd[c-3] = w_data8;
            end
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        mode;
        logic [31:0] scalar;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{3'd0, 1'b0, 32'h0,  32'd10,         32'd1,         32'd11};
        tbl[1]  = '{3'd1, 1'b1, 32'd5,  32'd3,          32'h77,        32'hFFFF_FFFE};
        tbl[2]  = '{3'd5, 1'b0, 32'h0,  32'd1,          32'd33,        32'd2};
        tbl[3]  = '{3'd7, 1'b1, 32'hA5, 32'h1234_5678,  32'h0,         32'hA5};
        tbl[4]  = '{3'd2, 1'b0, 32'h0,  32'hF0F0_F0F0,  32'hFF00_FF00, 32'hF000_F000};
        tbl[5]  = '{3'd3, 1'b0, 32'h0,  32'hF0F0_F0F0,  32'h0F0F_0000, 32'hFFFF_F0F0};
        tbl[6]  = '{3'd4, 1'b0, 32'h0,  32'hFFFF_0000,  32'h0FF0_0FF0, 32'hF00F_0FF0};
        tbl[7]  = '{3'd6, 1'b0, 32'h0,  32'h8000_0000,  32'd31,        32'd1};
        tbl[8]  = '{3'd6, 1'b0, 32'h0,  32'h8000_0000,  32'd32,        32'h8000_0000};
        tbl[9]  = '{3'd0, 1'b0, 32'h0,  32'hFFFF_FFFF,  32'd2,         32'd1};
        tbl[10] = '{3'd7, 1'b0, 32'h0,  32'd1,          32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[11] = '{3'd1, 1'b0, 32'h0,  32'd10,         32'd3,         32'd7};

        for (int i = 0; i < 8; i++) begin rf0[i] = 32'd0; rf1[i] = 32'd0; end
        for (int i = 0; i < 4; i++) begin rf4a[i] = 32'd0; rf4b[i] = 32'd0; end
        reset = 1'b1; start8 = 1'b0; start4 = 1'b0; op = 3'd0; mode = 1'b0; scalar = 32'd0;

        // Reset state, with start requests asserted to show reset wins.
        @(posedge clk);
        #1;
        start8 = 1'b1; start4 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0; start4 = 1'b0;
        @(negedge clk);
        chk("reset ready8", 32'(ready8), 32'd1);
        chk("reset w_en8", 32'(w_en8), 32'd0);
        chk("reset done8", 32'(done8), 32'd0);
        chk("reset r_addr8", 32'(r_addr8), 32'd0);
        chk("reset ready4", 32'(ready4), 32'd1);
        chk("reset w_en4", 32'(w_en4), 32'd0);
        reset = 1'b0;

        // Directed example: VV ADD on elements 1 and 5.
        rf0[1] = 32'd10; rf0[5] = 32'd20; rf1[1] = 32'd1; rf1[5] = 32'd2;
        run8(3'd0, 1'b0, 32'd0, 1'b0, 32'd0, "add_ex");
        chk("add_ex elem1", last_wd[0], 32'd11);
        chk("add_ex elem5", last_wd[1], 32'd22);

        // Table vectors: every element holds the same operands.
        foreach (tbl[i]) begin
            for (int a = 0; a < 8; a++) begin rf0[a] = tbl[i].a; rf1[a] = tbl[i].b; end
            run8(tbl[i].op, tbl[i].mode, tbl[i].scalar, 1'b1, tbl[i].exp,
                 $sformatf("tbl%0d", i));
        end

        // Random operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            for (int a = 0; a < 8; a++) begin
                rf0[a] = $urandom;
                rf1[a] = (i % 3 == 0) ? 32'($urandom_range(0, 70)) : $urandom;
            end
            run8(3'($urandom), 1'($urandom), $urandom, 1'b0, 32'd0, $sformatf("rnd%0d", i));
        end

        // start_i held high: one operation, next accepted only after done cycle.
        begin
            int nw;
            nw = 0;
            for (int a = 0; a < 8; a++) begin rf0[a] = a; rf1[a] = 32'd100; end
            @(negedge clk);
            op = 3'd0; mode = 1'b0; start8 = 1'b1;
            @(posedge clk);
            #1;
            for (int c = 1; c <= 7; c++) begin
                @(negedge clk);
                if (w_en8) nw++;
                chk($sformatf("hold c%0d ready", c), 32'(ready8), 32'(c == 6));
                chk($sformatf("hold c%0d done", c), 32'(done8), 32'(c == 5));
            end
            chk("hold writes", nw, 32'd2);
            chk("hold reissue r_addr", 32'(r_addr8), 32'd1);
            start8 = 1'b0;
            repeat (6) @(negedge clk);
            chk("hold final ready", 32'(ready8), 32'd1);
        end

        // Reset in cycle 3 of an ADD.
        @(negedge clk);
        op = 3'd0; mode = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst c3 w_en", 32'(w_en8), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("rst c%0d w_en", c), 32'(w_en8), 32'd0);
            chk($sformatf("rst c%0d done", c), 32'(done8), 32'd0);
            chk($sformatf("rst c%0d ready", c), 32'(ready8), 32'd1);
            chk($sformatf("rst c%0d r_addr", c), 32'(r_addr8), 32'd0);
        end

        // Single element per lane: vlen 4, lanes 4, lane 3.
        begin
            int nw;
            nw = 0;
            rf4a[3] = 32'd100; rf4b[3] = 32'd7;
            @(negedge clk);
            op = 3'd0; mode = 1'b0; start4 = 1'b1;
            @(posedge clk);
            #1;
            start4 = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                if (w_en4) nw++;
                chk($sformatf("e1 c%0d ready", c), 32'(ready4), 32'(c == 5));
                chk($sformatf("e1 c%0d done", c), 32'(done4), 32'(c == 4));
                chk($sformatf("e1 c%0d r_addr", c), 32'(r_addr4), (c == 1) ? 32'd3 : 32'd0);
                chk($sformatf("e1 c%0d w_en", c), 32'(w_en4), 32'(c == 3));
                if (c == 3 && w_en4) begin
                    chk("e1 w_addr", 32'(w_addr4), 32'd3);
                    chk("e1 w_data", w_data4, 32'd107);
                end
            end
            chk("e1 writes", nw, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
